// File: rtl/dfe_sched_pkg.sv
// Shared types, limits and the config legality check for the DFE rate scheduler.
package dfe_sched_pkg;

    localparam int unsigned DEF_MAX_IN_CYCLES = 16;
    localparam int unsigned DEF_MAX_CIC_DEC   = 64;
    localparam int unsigned CFG_W_C           = $clog2(DEF_MAX_IN_CYCLES + 1);
    localparam int unsigned CFG_W_D           = $clog2(DEF_MAX_CIC_DEC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [CFG_W_C-1:0] in_cycles;
        logic [CFG_W_C-1:0] out_pulses;
        logic [CFG_W_D-1:0] cic_dec;
    } rate_cfg_t;

    localparam rate_cfg_t RST_CFG = '{
        in_cycles:  CFG_W_C'(3),
        out_pulses: CFG_W_C'(2),
        cic_dec:    CFG_W_D'(4)
    };

    // A ratio is usable only if every field is non-zero, P fits in N and both fit the counters.
    function automatic bit cfg_legal(input rate_cfg_t cfg, input int unsigned max_in,
                                     input int unsigned max_dec);
        return (cfg.in_cycles != '0) && (cfg.out_pulses != '0) &&
               (cfg.out_pulses <= cfg.in_cycles) && (cfg.cic_dec != '0) &&
               (32'(cfg.in_cycles) <= max_in) && (32'(cfg.cic_dec) <= max_dec);
    endfunction

endpackage

// File: rtl/dfe_mod_counter.sv
// Modulo counter: counts 0..limit on en, wraps to 0, clr has priority.
module dfe_mod_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;

    // >= rather than == so a shrunken limit can never leave the count stranded above it.
    assign wrap  = en && (count_q >= limit);
    assign count = count_q;

    // Next count: clear, hold, or advance with wrap.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q >= limit) ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dfe_rate_scheduler.sv
// Frame sequencer for the DFE chain: fractional, IIR and CIC clock enables plus a
// frame-aligned rate-config handshake.
module dfe_rate_scheduler
    import dfe_sched_pkg::*;
#(
    parameter int unsigned MAX_IN_CYCLES  = DEF_MAX_IN_CYCLES,
    parameter int unsigned MAX_CIC_DEC    = DEF_MAX_CIC_DEC,
    parameter int unsigned RST_IN_CYCLES  = 32'(RST_CFG.in_cycles),
    parameter int unsigned RST_OUT_PULSES = 32'(RST_CFG.out_pulses),
    parameter int unsigned RST_CIC_DEC    = 32'(RST_CFG.cic_dec),
    localparam int unsigned W_C = $clog2(MAX_IN_CYCLES + 1),
    localparam int unsigned W_D = $clog2(MAX_CIC_DEC + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic           cfg_valid,
    input  logic [W_C-1:0] cfg_in_cycles,
    input  logic [W_C-1:0] cfg_out_pulses,
    input  logic [W_D-1:0] cfg_cic_dec,
    output logic           cfg_ack,
    output logic           cfg_err,
    output logic           frac_en,
    output logic           iir_en,
    output logic           cic_en,
    output logic           cic_out_en,
    output logic           busy
);

    localparam rate_cfg_t RESET_CFG = '{
        in_cycles:  CFG_W_C'(RST_IN_CYCLES),
        out_pulses: CFG_W_C'(RST_OUT_PULSES),
        cic_dec:    CFG_W_D'(RST_CIC_DEC)
    };

    sched_state_e state_q, state_d;
    rate_cfg_t    cfg_q, cfg_d, cfg_new;
    logic         stop_pend_q, stop_pend_d;
    logic         drain_cnt_q, drain_cnt_d;
    logic         frac_en_q, frac_en_d;
    logic         iir_en_q, iir_en_d;
    logic         cic_en_q, cic_en_d;
    logic         cfg_ack_q, cfg_ack_d;
    logic         cfg_err_q, cfg_err_d;
    logic         busy_q, busy_d;

    logic [CFG_W_C-1:0] phase_cnt;
    logic               phase_last;
    logic [CFG_W_D-1:0] unused_cic_cnt;
    logic               cic_wrap;
    logic               cfg_win;
    logic               cfg_ok;
    logic               cfg_apply;

    // Phase only advances in RUN; every other state holds it at 0 for a clean frame start.
    dfe_mod_counter #(
        .WIDTH (CFG_W_C)
    ) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .clr   (state_q != RUN),
        .limit (cfg_q.in_cycles - CFG_W_C'(1)),
        .count (phase_cnt),
        .wrap  (phase_last)
    );

    // CIC decimation count restarts with every accepted config so a new R never sees a torn count.
    dfe_mod_counter #(
        .WIDTH (CFG_W_D)
    ) u_cic_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cic_en_q),
        .clr   ((state_q == IDLE) || cfg_apply),
        .limit (cfg_q.cic_dec - CFG_W_D'(1)),
        .count (unused_cic_cnt),
        .wrap  (cic_wrap)
    );

    // Config window: any IDLE cycle, or the last phase of a RUN frame; never back-to-back acks.
    always_comb begin
        cfg_new.in_cycles  = cfg_in_cycles;
        cfg_new.out_pulses = cfg_out_pulses;
        cfg_new.cic_dec    = cfg_cic_dec;
        cfg_ok    = cfg_legal(cfg_new, MAX_IN_CYCLES, MAX_CIC_DEC);
        cfg_win   = cfg_valid && !cfg_ack_q && ((state_q == IDLE) || phase_last);
        cfg_apply = cfg_win && cfg_ok;
    end

    // Next-state for the sequencer FSM, config register and enable pipeline.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        drain_cnt_d = drain_cnt_q;
        cfg_d       = cfg_q;
        cfg_ack_d   = cfg_win;
        cfg_err_d   = cfg_win && !cfg_ok;
        frac_en_d   = 1'b0;
        iir_en_d    = frac_en_q;
        cic_en_d    = iir_en_q;

        if (cfg_apply) begin
            cfg_d = cfg_new;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    stop_pend_d = stop;
                end
            end
            RUN: begin
                frac_en_d = (phase_cnt < cfg_q.out_pulses);
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (phase_last && stop_pend_q) begin
                    state_d     = DRAIN;
                    stop_pend_d = 1'b0;
                    drain_cnt_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_q       <= RESET_CFG;
            stop_pend_q <= 1'b0;
            drain_cnt_q <= 1'b0;
            frac_en_q   <= 1'b0;
            iir_en_q    <= 1'b0;
            cic_en_q    <= 1'b0;
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            stop_pend_q <= stop_pend_d;
            drain_cnt_q <= drain_cnt_d;
            frac_en_q   <= frac_en_d;
            iir_en_q    <= iir_en_d;
            cic_en_q    <= cic_en_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_ack    = cfg_ack_q;
    assign cfg_err    = cfg_err_q;
    assign frac_en    = frac_en_q;
    assign iir_en     = iir_en_q;
    assign cic_en     = cic_en_q;
    assign cic_out_en = cic_wrap;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dfe_rate_scheduler.sv
// Bench for dfe_rate_scheduler: directed scenarios plus random episodes against a frame-level model.
module tb_dfe_rate_scheduler;

    localparam int W_C = 5;
    localparam int W_D = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [W_C-1:0] cfg_in_cycles = '0;
    logic [W_C-1:0] cfg_out_pulses = '0;
    logic [W_D-1:0] cfg_cic_dec = '0;
    logic cfg_ack, cfg_err, frac_en, iir_en, cic_en, cic_out_en, busy;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    string tag = "init";

    // Reference model: mode 0 idle, 1 run, 2 drain; k = cic_en events since last clear.
    int m_mode, m_pos, m_drain, m_n, m_p, m_r, m_k;
    bit m_stop;
    bit e_ack, e_err, e_frac, e_iir, e_cic, e_out, e_busy;

    always #5 clk = ~clk;

    dfe_rate_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .cfg_valid      (cfg_valid),
        .cfg_in_cycles  (cfg_in_cycles),
        .cfg_out_pulses (cfg_out_pulses),
        .cfg_cic_dec    (cfg_cic_dec),
        .cfg_ack        (cfg_ack),
        .cfg_err        (cfg_err),
        .frac_en        (frac_en),
        .iir_en         (iir_en),
        .cic_en         (cic_en),
        .cic_out_en     (cic_out_en),
        .busy           (busy)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic model_step();
        bit win, legal, f_now, i_now, c_now, old_stop;
        int n_in, p_in, r_in;
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_stop = 0; m_drain = 0;
            m_n = 3; m_p = 2; m_r = 4; m_k = 0;
            {e_ack, e_err, e_frac, e_iir, e_cic, e_out, e_busy} = '0;
            return;
        end
        f_now = e_frac; i_now = e_iir; c_now = e_cic; old_stop = m_stop;
        n_in = int'(cfg_in_cycles); p_in = int'(cfg_out_pulses); r_in = int'(cfg_cic_dec);
        legal = (n_in >= 1) && (p_in >= 1) && (p_in <= n_in) && (r_in >= 1) &&
                (n_in <= 16) && (r_in <= 64);
        win = cfg_valid && !e_ack && (m_mode == 0 || (m_mode == 1 && m_pos == m_n - 1));
        e_ack  = win;
        e_err  = win && !legal;
        e_frac = (m_mode == 1) && (m_pos < m_p);
        e_iir  = f_now;
        e_cic  = i_now;
        if (m_mode == 0 || (win && legal)) m_k = 0;
        else if (c_now) m_k++;
        case (m_mode)
            0: if (start) begin m_mode = 1; m_pos = 0; m_stop = stop; end
            1: begin
                if (stop) m_stop = 1;
                if (m_pos == m_n - 1) begin
                    m_pos = 0;
                    if (old_stop) begin m_mode = 2; m_drain = 2; m_stop = 0; end
                end else begin
                    m_pos++;
                end
            end
            default: begin
                m_drain--;
                if (m_drain == 0) m_mode = 0;
            end
        endcase
        if (win && legal) begin m_n = n_in; m_p = p_in; m_r = r_in; end
        e_busy = (m_mode != 0);
        e_out  = e_cic && ((m_k % m_r) == m_r - 1);
    endtask

    task automatic check_outputs();
        logic [6:0] obs, exp;
        obs = {cfg_ack, cfg_err, frac_en, iir_en, cic_en, cic_out_en, busy};
        exp = {e_ack, e_err, e_frac, e_iir, e_cic, e_out, e_busy};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d ack,err,frac,iir,cic,out,busy observed=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic check_val(input string t, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", t, cyc, obs, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_outputs();
        if (cfg_valid && e_ack) cfg_valid = 1'b0;
    endtask

    task automatic offer_cfg(input int n, input int p, input int r);
        cfg_in_cycles  = W_C'(n);
        cfg_out_pulses = W_C'(p);
        cfg_cic_dec    = W_D'(r);
        cfg_valid      = 1'b1;
    endtask

    task automatic rand_cfg();
        int n, p, r;
        n = $urandom_range(0, 18);
        p = $urandom_range(0, n + 1);
        r = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 9);
        offer_cfg(n, p, r);
    endtask

    task automatic wait_ack(input string t, input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (e_ack) break;
        end
        check_val({t, "_ack"}, int'(cfg_ack), 1);
    endtask

    task automatic wait_idle(input string t, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!e_busy && !cfg_valid) break;
            tick();
        end
        check_val({t, "_idle"}, int'(busy), 0);
    endtask

    task automatic collect_frac(input int n, output int bits);
        bits = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            bits = (bits << 1) | int'(frac_en);
        end
    endtask

    int bits, sf, sc, so;

    initial begin
        // Reset state
        tag = "reset";
        tick(); tick();
        check_val("reset_outputs", int'({cfg_ack, cfg_err, frac_en, iir_en, cic_en, cic_out_en,
                                         busy}), 0);
        rst_n = 1'b1;
        tick();

        // 1: default 3/2/4 frame pattern
        tag = "t1";
        start = 1'b1; tick(); start = 1'b0;
        collect_frac(9, bits);
        check_val("t1_frac_pattern", bits, 'b110110110);

        // 2: 5/4/2 offered mid-frame, takes effect at the next frame
        tag = "t2";
        tick();
        offer_cfg(5, 4, 2);
        wait_ack("t2", 20);
        check_val("t2_err", int'(cfg_err), 0);
        collect_frac(5, bits);
        check_val("t2_frac_pattern", bits, 'b11110);

        // 3: illegal P>N rejected, pattern kept, legal config still accepted
        tag = "t3";
        offer_cfg(3, 4, 4);
        wait_ack("t3_bad", 20);
        check_val("t3_err_bad", int'(cfg_err), 1);
        collect_frac(5, bits);
        check_val("t3_frac_kept", bits, 'b11110);
        offer_cfg(3, 2, 4);
        wait_ack("t3_good", 20);
        check_val("t3_err_good", int'(cfg_err), 0);
        collect_frac(3, bits);
        check_val("t3_frac_new", bits, 'b110);

        // 4: stop at phase 0, drain, return to IDLE
        tag = "t4";
        for (int i = 0; i < 5 && m_pos != 0; i++) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        bits = int'(frac_en);
        tick(); bits = (bits << 1) | int'(frac_en);
        tick(); bits = (bits << 1) | int'(frac_en);
        check_val("t4_frac_tail", bits, 'b110);
        tick();
        check_val("t4_busy_drain", int'(busy), 1);
        tick();
        check_val("t4_idle_outputs", int'({frac_en, iir_en, cic_en, cic_out_en, busy}), 0);

        // 5: reset mid-run restores defaults
        tag = "t5";
        offer_cfg(5, 4, 2);
        wait_ack("t5_cfg", 5);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6 && !e_frac; i++) tick();
        check_val("t5_frac_before_reset", int'(frac_en), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check_val("t5_reset_outputs", int'({cfg_ack, cfg_err, frac_en, iir_en, cic_en,
                                            cic_out_en, busy}), 0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        collect_frac(9, bits);
        check_val("t5_frac_default", bits, 'b110110110);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle("t5", 20);

        // 6: N=P=R=1 with start+stop together
        tag = "t6";
        offer_cfg(1, 1, 1);
        wait_ack("t6_cfg", 5);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        sf = 0; sc = 0; so = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            sf += int'(frac_en); sc += int'(cic_en); so += int'(cic_out_en);
        end
        check_val("t6_frac_count", sf, 1);
        check_val("t6_cic_count", sc, 1);
        check_val("t6_cic_out_count", so, 1);
        check_val("t6_busy_end", int'(busy), 0);

        // Random episodes against the model
        tag = "rand";
        for (int ep = 0; ep < 30; ep++) begin
            int len;
            if ($urandom_range(0, 1) == 1) begin
                rand_cfg();
                wait_ack("rand_idle_cfg", 5);
            end
            start = 1'b1; tick(); start = 1'b0;
            len = $urandom_range(8, 60);
            for (int c = 0; c < len; c++) begin
                if (!cfg_valid && $urandom_range(0, 9) == 0) rand_cfg();
                stop = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 79) == 0) begin
                    rst_n = 1'b0;
                    cfg_valid = 1'b0;
                end
                tick();
                stop = 1'b0;
                rst_n = 1'b1;
                if (m_mode == 0 && $urandom_range(0, 3) == 0) begin
                    start = 1'b1; tick(); start = 1'b0;
                end
            end
            stop = 1'b1; tick(); stop = 1'b0;
            wait_idle("rand", 80);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
